accum_driver: RTL and testbench

- Initiator-side sequencer for the start/inputC/inputB/inputA accumulate-and-stop protocol used by the W-bit accumulator FSMD (start, per-element C/B phases, sticky done, W-bit value).
- Buffers up to DEPTH operands, then replays them to the accumulator in lockstep, one element per C/B phase pair.
- Keeps its own modulo-2^W expected sum, captures the accumulator's value when done rises, and reports match or protocol error.
- Used as the on-chip stimulus source and checker for the accumulator datapath.

---
 rtl/accum_driver.sv | 168 ++++++++++++++++
 tb/tb_accum_driver.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_driver.sv
// Initiator-side sequencer and checker for the start/inputC/inputB/inputA accumulator.
// Buffers operands, replays them in lockstep with the accumulator FSMD, then compares its sum.
module accum_driver #(
    parameter int W       = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         load_add,
    output logic         load_ready,
    input  logic         go,
    input  logic         clear,
    output logic         busy,
    output logic         finished,
    output logic [W-1:0] result,
    output logic [W-1:0] expected,
    output logic         match,
    output logic         error,
    output logic         acc_start,
    output logic         acc_inputC,
    output logic         acc_inputB,
    output logic [W-1:0] acc_inputA,
    input  logic         acc_done,
    input  logic [W-1:0] acc_value
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, START, C_PHASE, B_PHASE, WAIT_DONE, DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic         add;
    } entry_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, idx;
    logic [TW-1:0]   tcnt;
    entry_t          buffer [0:(1<<AW)-1];
    entry_t          cur;
    logic            more, timed_out, load_fire;

    assign cur       = buffer[idx[AW-1:0]];
    assign more      = idx < count;
    assign timed_out = (tcnt + TW'(1)) == TIMEOUT_C;
    assign load_fire = load_valid && load_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (go) state_nxt = START;
            START:     state_nxt = C_PHASE;
            C_PHASE:   state_nxt = more ? B_PHASE : WAIT_DONE;
            B_PHASE:   state_nxt = C_PHASE;
            WAIT_DONE: if (acc_done || timed_out) state_nxt = DONE;
            DONE:      if (clear) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Early acc_done during the replay is a protocol error, but the replay still runs to the end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            idx      <= '0;
            tcnt     <= '0;
            expected <= '0;
            result   <= '0;
            match    <= 1'b0;
            error    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        idx      <= '0;
                        expected <= '0;
                        result   <= '0;
                        match    <= 1'b0;
                        error    <= 1'b0;
                    end else if (load_fire) begin
                        count <= count + CW'(1);
                    end
                end
                START: begin
                    if (acc_done) error <= 1'b1;
                end
                C_PHASE: begin
                    if (acc_done) error <= 1'b1;
                    if (!more)    tcnt  <= '0;
                end
                B_PHASE: begin
                    if (acc_done) error <= 1'b1;
                    if (cur.add)  expected <= expected + cur.data;
                    idx <= idx + CW'(1);
                end
                WAIT_DONE: begin
                    if (acc_done) begin
                        result <= acc_value;
                        match  <= (acc_value == expected);
                    end else if (timed_out) begin
                        error <= 1'b1;
                        match <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE: begin
                    if (clear) begin
                        count <= '0;
                        idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand store has no reset; it is only read at indices written since the last go.
    always_ff @(posedge clock) begin
        if (load_fire) buffer[count[AW-1:0]] <= '{data: load_data, add: load_add};
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        acc_start  = 1'b0;
        acc_inputC = 1'b0;
        acc_inputB = 1'b0;
        acc_inputA = '0;
        unique case (state)
            IDLE:      load_ready = !go && (count < DEPTH_C);
            START: begin
                busy      = 1'b1;
                acc_start = 1'b1;
            end
            C_PHASE: begin
                busy       = 1'b1;
                acc_inputC = more;
            end
            B_PHASE: begin
                busy       = 1'b1;
                acc_inputA = cur.data;
                acc_inputB = cur.add;
            end
            WAIT_DONE: busy     = 1'b1;
            DONE:      finished = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_accum_driver.sv
// Self-checking bench for accum_driver: a behavioural accumulator answers the protocol and
// a scoreboard of expected results is popped when finished rises.
module tb_accum_driver;

    localparam int W       = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         load_valid, load_add, load_ready, go, clear;
    logic [W-1:0] load_data;
    logic         busy, finished, match, error;
    logic [W-1:0] result, expected;
    logic         acc_start, acc_inputC, acc_inputB, acc_done;
    logic [W-1:0] acc_inputA, acc_value;

    accum_driver #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_add(load_add), .load_ready(load_ready),
        .go(go), .clear(clear), .busy(busy), .finished(finished),
        .result(result), .expected(expected), .match(match), .error(error),
        .acc_start(acc_start), .acc_inputC(acc_inputC), .acc_inputB(acc_inputB),
        .acc_inputA(acc_inputA), .acc_done(acc_done), .acc_value(acc_value)
    );

    always #5 clock = ~clock;

    // Behavioural accumulator: idle -> checkC <-> checkB -> stop (sticky until acc_rst).
    localparam logic [1:0] M_IDLE = 2'd0, M_CHKC = 2'd1, M_CHKB = 2'd2, M_STOP = 2'd3;
    logic [1:0]   m_mode;
    logic [W-1:0] m_sum;
    logic         acc_rst, hold_low, inject_b;

    always @(posedge clock) begin
        if (acc_rst) begin
            m_mode <= M_IDLE;
            m_sum  <= '0;
        end else begin
            case (m_mode)
                M_IDLE: if (acc_start) begin m_mode <= M_CHKC; m_sum <= '0; end
                M_CHKC: m_mode <= acc_inputC ? M_CHKB : M_STOP;
                M_CHKB: begin
                    if (acc_inputB) m_sum <= m_sum + acc_inputA;
                    m_mode <= M_CHKC;
                end
                default: m_mode <= M_STOP;
            endcase
        end
    end

    assign acc_done  = ((m_mode == M_STOP) && !hold_low) || (inject_b && acc_inputB);
    assign acc_value = m_sum;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] sum;
        logic         mat;
        logic         err;
        bit           chk_res;
        int           lat;
    } sb_t;

    sb_t          sb_q[$];
    logic [W-1:0] op_data[$];
    logic         op_add[$];
    int           tot = 0;
    int           bad = 0;

    task automatic reset_model();
        acc_rst = 1'b1;
        @(negedge clock);
        acc_rst = 1'b0;
        op_data.delete();
        op_add.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tot++;
        if ({busy, finished, match, error, acc_start, acc_inputC, acc_inputB, load_ready} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000001",
                     {busy, finished, match, error, acc_start, acc_inputC, acc_inputB, load_ready});
        end
        tot++;
        if ({result, expected, acc_inputA} !== '0) begin
            bad++;
            $display("FAIL reset_values: got result=%0d expected=%0d acc_inputA=%0d want 0",
                     result, expected, acc_inputA);
        end
        reset = 1'b0;
        reset_model();
    endtask

    task automatic load_op(input logic [W-1:0] d, input logic a);
        logic exp_ready;
        exp_ready  = (op_data.size() < DEPTH);
        load_valid = 1'b1;
        load_data  = d;
        load_add   = a;
        #1;
        tot++;
        if (load_ready !== exp_ready) begin
            bad++;
            $display("FAIL load_ready (entry %0d): got %b want %b", op_data.size(), load_ready, exp_ready);
        end
        @(negedge clock);
        load_valid = 1'b0;
        if (exp_ready) begin
            op_data.push_back(d);
            op_add.push_back(a);
        end
    endtask

    // Launches a replay, checks the per-cycle protocol, then pops the scoreboard on finished.
    task automatic run(input string name, input bit extra_load);
        int           n, fin_t, c_bad, b_bad;
        bit           start_ok;
        logic [W-1:0] s;
        sb_t          e, got;
        n = op_data.size();
        s = '0;
        foreach (op_data[k]) if (op_add[k]) s = s + op_data[k];
        e.res     = s;
        e.sum     = s;
        e.mat     = !hold_low;
        e.err     = hold_low || inject_b;
        e.chk_res = !hold_low;
        e.lat     = hold_low ? 2*n + 3 + TIMEOUT : 2*n + 4;
        sb_q.push_back(e);

        go = 1'b1;
        if (extra_load) begin
            load_valid = 1'b1;
            load_data  = 8'hAA;
            load_add   = 1'b1;
        end
        #1;
        if (extra_load) begin
            tot++;
            if (load_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s go_blocks_load: load_ready got %b want 0", name, load_ready);
            end
        end
        @(posedge clock);
        @(negedge clock);
        go = 1'b0;
        load_valid = 1'b0;

        fin_t = -1; c_bad = 0; b_bad = 0; start_ok = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            if (acc_start !== (t == 1)) start_ok = 1'b0;
            if ((t % 2 == 0) && (t <= 2*n + 2) && (acc_inputC !== (t < 2*n + 2))) c_bad++;
            if ((t % 2 == 1) && (t >= 3) && (t <= 2*n + 1)) begin
                if ({acc_inputA, acc_inputB} !== {op_data[(t-3)/2], op_add[(t-3)/2]}) b_bad++;
            end
            if (finished === 1'b1) begin
                fin_t = t;
                break;
            end
            @(negedge clock);
        end

        tot++;
        if (!start_ok) begin bad++; $display("FAIL %s acc_start: not a single pulse one cycle after go", name); end
        tot++;
        if (c_bad != 0) begin bad++; $display("FAIL %s acc_inputC: %0d wrong C_PHASE cycles, want 0", name, c_bad); end
        tot++;
        if (b_bad != 0) begin bad++; $display("FAIL %s acc_inputA/B: %0d wrong B_PHASE cycles, want 0", name, b_bad); end
        got = sb_q.pop_front();
        tot++;
        if (fin_t != got.lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, fin_t, got.lat); end
        if (fin_t < 0) begin
            $display("FAIL %s timeout: finished never rose", name);
            $fatal(1, "test done: total=%0d bad=%0d", tot, bad);
        end
        if (got.chk_res) begin
            tot++;
            if (result !== got.res) begin bad++; $display("FAIL %s result: got %0d want %0d", name, result, got.res); end
        end
        tot++;
        if (expected !== got.sum) begin bad++; $display("FAIL %s expected: got %0d want %0d", name, expected, got.sum); end
        tot++;
        if (match !== got.mat) begin bad++; $display("FAIL %s match: got %b want %b", name, match, got.mat); end
        tot++;
        if (error !== got.err) begin bad++; $display("FAIL %s error: got %b want %b", name, error, got.err); end

        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        tot++;
        if (finished !== 1'b1) begin bad++; $display("FAIL %s go_in_done: finished got %b want 1", name, finished); end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        tot++;
        if ({busy, finished, load_ready} !== 3'b001) begin
            bad++;
            $display("FAIL %s clear: busy/finished/load_ready got %b want 001", name, {busy, finished, load_ready});
        end
        reset_model();
    endtask

    task automatic test_basic();
        load_op(8'd3, 1'b1); load_op(8'd5, 1'b1); load_op(8'd7, 1'b1);
        run("basic", 1'b0);
    endtask

    task automatic test_wrap();
        load_op(8'd200, 1'b1); load_op(8'd100, 1'b1);
        run("wrap", 1'b0);
    endtask

    task automatic test_skip();
        load_op(8'd4, 1'b1); load_op(8'd9, 1'b0); load_op(8'd6, 1'b1);
        run("skip", 1'b0);
    endtask

    task automatic test_empty();
        run("empty", 1'b0);
    endtask

    task automatic test_back_to_back_fill();
        for (int i = 0; i < DEPTH + 1; i++) load_op(W'(i*37 + 11), (i % 3) != 1);
        run("fill", 1'b1);
    endtask

    task automatic test_timeout();
        hold_low = 1'b1;
        load_op(8'd12, 1'b1); load_op(8'd30, 1'b1);
        run("timeout", 1'b0);
        hold_low = 1'b0;
    endtask

    task automatic test_done_in_b();
        inject_b = 1'b1;
        load_op(8'd1, 1'b1); load_op(8'd2, 1'b1);
        run("done_in_b", 1'b0);
        inject_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_op(8'd5, 1'b1); load_op(8'd6, 1'b1);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (acc_inputB === 1'b1) begin seen = 1'b1; break; end
            @(negedge clock);
        end
        tot++;
        if (!seen) begin bad++; $display("FAIL reset_mid: B_PHASE not reached within 20 cycles"); end
        reset = 1'b1;
        #1;
        tot++;
        if ({busy, finished, match, error, acc_start, acc_inputC, acc_inputB, load_ready} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_mid_flags: got %b want 00000001",
                     {busy, finished, match, error, acc_start, acc_inputC, acc_inputB, load_ready});
        end
        tot++;
        if ({result, expected, acc_inputA} !== '0) begin
            bad++;
            $display("FAIL reset_mid_values: got result=%0d expected=%0d acc_inputA=%0d want 0",
                     result, expected, acc_inputA);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tot++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_idle: busy got %b want 0", busy); end
        reset_model();
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; clear = 1'b0;
        load_valid = 1'b0; load_data = '0; load_add = 1'b0;
        acc_rst = 1'b1; hold_low = 1'b0; inject_b = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_skip();
        test_empty();
        test_back_to_back_fill();
        test_timeout();
        test_done_in_b();
        test_reset_mid();
        test_basic();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
